// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: default depth and drain FSM state encodings.
package uart_tx_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_RDY  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/UART-facing signal bundle of the UART transmit FIFO.
// The slave side is the FIFO; the master side is the producer plus the UART DIN/OE/RDY port.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_en;
    logic          flush;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          ovf;
    logic [7:0]    tx_din;
    logic          tx_oe;
    logic          tx_rdy;

    modport master (
        output wr_data, wr_en, flush, tx_rdy,
        input  full, empty, level, ovf, tx_din, tx_oe
    );

    modport slave (
        input  wr_data, wr_en, flush, tx_rdy,
        output full, empty, level, ovf, tx_din, tx_oe
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Depth x 8 byte storage: one synchronous write port, combinational read.
// Contents are not reset; validity is tracked by the owner's pointers.
module sync_fifo_mem #(
    parameter int Depth = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(Depth)-1:0]   waddr,
    input  logic [7:0]                 wdata,
    input  logic [$clog2(Depth)-1:0]   raddr,
    output logic [7:0]                 rdata
);

    logic [7:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; WR_EN -> TX_OE latency 2 cycles with the UART idle.
// Writes while full are dropped and flagged sticky in ovf; drain waits on the UART RDY handshake.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int Depth = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);

    localparam int          AW       = $clog2(Depth);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(Depth);

    logic [AW:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n, level_q;
    logic         full_q, empty_q, ovf_q, tx_oe_q;
    logic [7:0]   tx_din_q, rd_data;
    logic         push, pop;
    drain_state_e state_q, state_n;

    // Flags are registered, so a pop in this cycle cannot make room for a write in this cycle.
    assign push = bus.wr_en && !full_q && !bus.flush;
    assign pop  = (state_q == IDLE) && !empty_q && bus.tx_rdy && !bus.flush;

    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        if (bus.flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end else begin
            if (push) wr_ptr_n = wr_ptr + PTR_ONE;
            if (pop)  rd_ptr_n = rd_ptr + PTR_ONE;
        end
    end

    assign level_n = wr_ptr_n - rd_ptr_n;

    // WAIT_BUSY keeps a lagging RDY from triggering a second issue of the same slot.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:      if (pop) state_n = ISSUE;
            ISSUE:     state_n = bus.tx_rdy ? WAIT_BUSY : WAIT_RDY;
            WAIT_BUSY: if (!bus.tx_rdy) state_n = WAIT_RDY;
            WAIT_RDY:  if (bus.tx_rdy) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tx_oe_q  <= 1'b0;
            tx_din_q <= 8'h00;
        end else begin
            state_q <= state_n;
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            level_q <= level_n;
            empty_q <= (level_n == '0);
            full_q  <= (level_n == LVL_FULL);
            if (bus.wr_en && full_q && !bus.flush) begin
                ovf_q <= 1'b1;
            end
            tx_oe_q <= pop;
            if (pop) begin
                tx_din_q <= rd_data;
            end
        end
    end

    sync_fifo_mem #(
        .Depth (Depth)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    assign bus.full   = full_q;
    assign bus.empty  = empty_q;
    assign bus.level  = level_q;
    assign bus.ovf    = ovf_q;
    assign bus.tx_oe  = tx_oe_q;
    assign bus.tx_din = tx_din_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a UART model: RDY drops 1 cycle after OE, rises 10 cycles later.
module tb_uart_tx_fifo;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(16)) bus ();

    uart_tx_fifo #(.Depth(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // UART model; hold forces RDY low to let the FIFO fill up.
    logic mdl_rdy  = 1'b1;
    logic mdl_pend = 1'b0;
    int   mdl_cnt  = 0;
    logic hold     = 1'b0;
    assign bus.tx_rdy = mdl_rdy & ~hold;

    always @(posedge clk) begin
        #2;
        if (mdl_pend) begin
            mdl_pend = 1'b0;
            mdl_rdy  = 1'b0;
            mdl_cnt  = 10;
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) mdl_rdy = 1'b1;
        end
        if (bus.tx_oe) mdl_pend = 1'b1;
    end

    // Strobe monitor: captured bytes, handshake violations, strobes longer than one cycle.
    logic [7:0] oe_q[$];
    int viol    = 0;
    int oe_long = 0;
    bit have_prev = 0, seen_low = 0, seen_high = 0, prev_oe = 0;

    always @(negedge clk) begin
        if (bus.tx_oe) begin
            oe_q.push_back(bus.tx_din);
            if (have_prev && !(seen_low && seen_high)) viol++;
            if (prev_oe) oe_long++;
            have_prev = 1;
            seen_low  = 0;
            seen_high = 0;
        end else if (!bus.tx_rdy) begin
            seen_low = 1;
        end else if (seen_low) begin
            seen_high = 1;
        end
        prev_oe = bus.tx_oe;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        oe_q.delete();
        have_prev = 0;
    endtask

    task automatic wait_oe(input int n, input int budget, input string tag);
        int k = 0;
        while (oe_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(oe_q.size() >= n), 32'd1);
    endtask

    task automatic write1(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        int aa_seen;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush   = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full),  32'd0);
        chk("rst_ovf",   32'(bus.ovf),   32'd0);
        chk("rst_oe",    32'(bus.tx_oe), 32'd0);
        chk("rst_din",   32'(bus.tx_din), 32'h00);
        rst_n = 1'b1;
        step();

        // 1: single byte, 2-cycle latency, 1-cycle strobe
        clear_mon();
        write1(8'h41);
        chk("t1_oe_c1", 32'(bus.tx_oe), 32'd0);
        step();
        chk("t1_oe_c2", 32'(bus.tx_oe), 32'd1);
        chk("t1_din",   32'(bus.tx_din), 32'h41);
        step();
        chk("t1_oe_c3", 32'(bus.tx_oe), 32'd0);
        chk("t1_level", 32'(bus.level), 32'd0);
        chk("t1_empty", 32'(bus.empty), 32'd1);
        repeat (14) step();

        // 2: burst of 16 with RDY low, then drain in order
        clear_mon();
        hold = 1'b1;
        for (int i = 0; i < 16; i++) write1(8'(i));
        chk("t2_full",  32'(bus.full),  32'd1);
        chk("t2_level", 32'(bus.level), 32'd16);
        hold = 1'b0;
        wait_oe(16, 400, "t2_drain_timeout");
        chk("t2_count", 32'(oe_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < oe_q.size(); i++)
            chk("t2_order", 32'(oe_q[i]), 32'(i));
        chk("t2_handshake_viol", 32'(viol), 32'd0);
        repeat (14) step();

        // 3: overflow, dropped byte, sticky flag
        clear_mon();
        hold = 1'b1;
        for (int i = 0; i < 16; i++) write1(8'h20 + 8'(i));
        write1(8'hAA);
        step();
        chk("t3_ovf",   32'(bus.ovf),   32'd1);
        chk("t3_level", 32'(bus.level), 32'd16);
        hold = 1'b0;
        wait_oe(16, 400, "t3_drain_timeout");
        step();
        aa_seen = 0;
        foreach (oe_q[i]) if (oe_q[i] == 8'hAA) aa_seen++;
        chk("t3_aa_seen", 32'(aa_seen), 32'd0);
        chk("t3_count",   32'(oe_q.size()), 32'd16);
        chk("t3_last",    32'(oe_q[15]), 32'h2F);
        chk("t3_ovf_sticky", 32'(bus.ovf), 32'd1);
        repeat (14) step();

        // 4: simultaneous write and pop at level 5, order across wrap
        clear_mon();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) write1(8'h50 + 8'(i));
        chk("t4_level_pre", 32'(bus.level), 32'd5);
        hold = 1'b0;
        write1(8'h55);
        chk("t4_level_same", 32'(bus.level), 32'd5);
        chk("t4_oe",  32'(bus.tx_oe), 32'd1);
        chk("t4_din", 32'(bus.tx_din), 32'h50);
        for (int i = 6; i < 16; i++) write1(8'h50 + 8'(i));
        wait_oe(5, 200, "t4_mid_timeout");
        for (int i = 16; i < 20; i++) write1(8'h50 + 8'(i));
        wait_oe(20, 400, "t4_drain_timeout");
        chk("t4_count", 32'(oe_q.size()), 32'd20);
        for (int i = 0; i < 20 && i < oe_q.size(); i++)
            chk("t4_order", 32'(oe_q[i]), 32'(8'h50 + 8'(i)));
        repeat (14) step();

        // 5: flush during WAIT_BUSY with 3 queued
        clear_mon();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) write1(8'h70 + 8'(i));
        hold = 1'b0;
        step();
        chk("t5_oe",    32'(bus.tx_oe), 32'd1);
        chk("t5_level", 32'(bus.level), 32'd3);
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t5_empty", 32'(bus.empty), 32'd1);
        chk("t5_level_flushed", 32'(bus.level), 32'd0);
        repeat (30) step();
        chk("t5_count", 32'(oe_q.size()), 32'd1);
        chk("t5_inflight", 32'(oe_q[0]), 32'h70);
        chk("t5_ovf_kept", 32'(bus.ovf), 32'd1);

        // 6: async reset mid-ISSUE
        clear_mon();
        write1(8'h99);
        step();
        chk("t6_oe_pre", 32'(bus.tx_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_oe_async",    32'(bus.tx_oe), 32'd0);
        chk("t6_empty_async", 32'(bus.empty), 32'd1);
        chk("t6_ovf_async",   32'(bus.ovf),   32'd0);
        step();
        rst_n = 1'b1;
        clear_mon();
        repeat (30) step();
        chk("t6_no_spurious", 32'(oe_q.size()), 32'd0);
        chk("t6_empty_after", 32'(bus.empty), 32'd1);

        chk("oe_one_cycle", 32'(oe_long), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
